// File: rtl/seqcordic_gen.sv
// Sequential CORDIC engine: one micro-rotation per clock, rotate or vector mode per request.
// Optional macro SEQCORDIC_GAIN_COMP_EN adds a GAIN state that removes the CORDIC gain.
module seqcordic_gen #(
  parameter int unsigned IW      = 16,
  parameter int unsigned OW      = 16,
  parameter int unsigned PW      = 32,
  parameter int unsigned NSTAGES = 19,
  parameter int unsigned XTRA    = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic          i_mode,
  input  logic [IW-1:0] i_xval,
  input  logic [IW-1:0] i_yval,
  input  logic [PW-1:0] i_phase,
  output logic          o_busy,
  output logic          o_done,
  output logic [OW-1:0] o_xval,
  output logic [OW-1:0] o_yval,
  output logic [PW-1:0] o_phase
);
  localparam int unsigned WW = IW + XTRA + 2;
  // LSBs dropped between the working word and the output tap; must be at least 1.
  localparam int unsigned RS = WW - 2 - OW;
  localparam logic [PW-1:0] Half    = {1'b1, {(PW - 1){1'b0}}};
  localparam logic [PW-1:0] Quarter = {2'b01, {(PW - 2){1'b0}}};

`ifdef SEQCORDIC_GAIN_COMP_EN
  typedef enum logic [2:0] {StIdle, StPre, StIter, StGain, StOut} state_e;
`else
  typedef enum logic [2:0] {StIdle, StPre, StIter, StOut} state_e;
`endif

  // atan(2^-k) as a fraction of 2^32 per full circle, rounded to PW bits.
  function automatic logic [PW-1:0] angle_lut(input logic [4:0] k);
    logic [31:0] a;
    logic [32:0] r;
    case (k)
      5'd0:  a = 32'h20000000;  5'd1:  a = 32'h12e4051e;
      5'd2:  a = 32'h09fb385b;  5'd3:  a = 32'h051111d4;
      5'd4:  a = 32'h028b0d43;  5'd5:  a = 32'h0145d7e1;
      5'd6:  a = 32'h00a2f61e;  5'd7:  a = 32'h00517c55;
      5'd8:  a = 32'h0028be53;  5'd9:  a = 32'h00145f2f;
      5'd10: a = 32'h000a2f98;  5'd11: a = 32'h000517cc;
      5'd12: a = 32'h00028be6;  5'd13: a = 32'h000145f3;
      5'd14: a = 32'h0000a2f9;  5'd15: a = 32'h0000517d;
      5'd16: a = 32'h000028be;  5'd17: a = 32'h0000145f;
      5'd18: a = 32'h00000a30;  5'd19: a = 32'h00000518;
      5'd20: a = 32'h0000028c;  5'd21: a = 32'h00000146;
      5'd22: a = 32'h000000a3;  5'd23: a = 32'h00000051;
      5'd24: a = 32'h00000029;  5'd25: a = 32'h00000014;
      5'd26: a = 32'h0000000a;  5'd27: a = 32'h00000005;
      5'd28: a = 32'h00000003;  5'd29: a = 32'h00000001;
      5'd30: a = 32'h00000001;
      default: a = 32'h00000000;
    endcase
    r = {a, 1'b0} + (33'd1 << (32 - PW));
    return PW'(r >> (33 - PW));
  endfunction

  // Round half-to-even onto the output tap, then clamp symmetrically.
  function automatic logic [OW-1:0] round_sat(input logic signed [WW-1:0] v);
    logic signed [WW:0] ve, r, q, maxv;
    ve   = (WW + 1)'(v);
    r    = ve + (WW + 1)'((1 << (RS - 1)) - 1) + (WW + 1)'(v[RS]);
    q    = r >>> RS;
    maxv = (WW + 1)'((1 << (OW - 1)) - 1);
    if (q > maxv)       return OW'(maxv);
    else if (q < -maxv) return OW'(-maxv);
    else                return OW'(q);
  endfunction

`ifdef SEQCORDIC_GAIN_COMP_EN
  // 1/G in Q0.32 for the given stage count.
  function automatic logic [31:0] gain_inv(input int unsigned n);
    case (n)
      8:       return 32'd2608158028;
      9:       return 32'd2608138129;
      10:      return 32'd2608133154;
      11:      return 32'd2608131911;
      12:      return 32'd2608131600;
      13:      return 32'd2608131522;
      14:      return 32'd2608131502;
      15:      return 32'd2608131498;
      default: return 32'h9b74eda8;
    endcase
  endfunction
  localparam logic [32:0] GainK = {1'b0, gain_inv(NSTAGES)};
  logic signed [WW+32:0] px, py;
`endif

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d, xs, ys;
  logic [PW-1:0]        ph_q, ph_d, ang_q, ang_d;
  logic [4:0]           k_q, k_d;
  logic                 pos;
  logic [OW-1:0]        xo_q, xo_d, yo_q, yo_d;
  logic [PW-1:0]        pho_q, pho_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    ang_d   = ang_q;
    k_d     = k_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    pho_d   = pho_q;
    done_d  = 1'b0;
    xs      = x_q >>> k_q;
    ys      = y_q >>> k_q;
    pos     = mode_q ? y_q[WW-1] : ~ph_q[PW-1];
`ifdef SEQCORDIC_GAIN_COMP_EN
    px      = (WW + 33)'(x_q) * (WW + 33)'($signed(GainK));
    py      = (WW + 33)'(y_q) * (WW + 33)'($signed(GainK));
`endif
    case (state_q)
      StIdle: begin
        if (i_stb) begin
          state_d = StPre;
          mode_d  = i_mode;
          x_d     = WW'($signed(i_xval)) <<< XTRA;
          y_d     = WW'($signed(i_yval)) <<< XTRA;
          ph_d    = i_phase;
        end
      end
      StPre: begin
        state_d = StIter;
        k_d     = '0;
        ang_d   = angle_lut(5'd0);
        if (mode_q) begin
          ph_d = '0;
          if (x_q[WW-1]) begin
            x_d  = -x_q;
            y_d  = -y_q;
            ph_d = Half;
          end
        end else begin
          // Fold the angle into [-45, 45) degrees with a 0/90/180/270 pre-rotation.
          case (ph_q[PW-1 -: 3])
            3'b001, 3'b010: begin x_d = -y_q; y_d = x_q;  ph_d = ph_q - Quarter; end
            3'b011, 3'b100: begin x_d = -x_q; y_d = -y_q; ph_d = ph_q - Half;    end
            3'b101, 3'b110: begin x_d = y_q;  y_d = -x_q; ph_d = ph_q + Quarter; end
            default: ;
          endcase
        end
      end
      StIter: begin
        if (pos) begin
          x_d  = x_q - ys;
          y_d  = y_q + xs;
          ph_d = ph_q - ang_q;
        end else begin
          x_d  = x_q + ys;
          y_d  = y_q - xs;
          ph_d = ph_q + ang_q;
        end
        k_d   = k_q + 5'd1;
        ang_d = angle_lut(k_q + 5'd1);
        if (k_q == 5'(NSTAGES - 1)) begin
`ifdef SEQCORDIC_GAIN_COMP_EN
          state_d = StGain;
`else
          state_d = StOut;
`endif
        end
      end
`ifdef SEQCORDIC_GAIN_COMP_EN
      StGain: begin
        x_d     = WW'(px >>> 32);
        y_d     = WW'(py >>> 32);
        state_d = StOut;
      end
`endif
      StOut: begin
        xo_d    = round_sat(x_q);
        yo_d    = round_sat(y_q);
        pho_d   = ph_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= '0;
      ang_q   <= '0;
      k_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      pho_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      ang_q   <= ang_d;
      k_q     <= k_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      pho_q   <= pho_d;
      done_q  <= done_d;
    end
  end

  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;
  assign o_xval  = xo_q;
  assign o_yval  = yo_q;
  assign o_phase = pho_q;

endmodule

// File: tb/tb_seqcordic_gen.sv
// Directed self-checking bench for seqcordic_gen at default parameters.
module tb_seqcordic_gen;
  localparam int unsigned IW = 16, OW = 16, PW = 32, NSTAGES = 19, XTRA = 3;
  localparam longint Lat = NSTAGES + 2;
  localparam longint Ang18 = 2608;

  logic          clk = 1'b0;
  logic          rst, stb, mode;
  logic [IW-1:0] xv, yv;
  logic [PW-1:0] ph;
  logic          busy, done;
  logic [OW-1:0] xo, yo;
  logic [PW-1:0] pho;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seqcordic_gen #(.IW(IW), .OW(OW), .PW(PW), .NSTAGES(NSTAGES), .XTRA(XTRA)) dut (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_mode(mode), .i_xval(xv), .i_yval(yv),
    .i_phase(ph), .o_busy(busy), .o_done(done), .o_xval(xo), .o_yval(yo), .o_phase(pho)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic m, input longint x, input longint y, input longint p);
    mode = m;
    xv   = IW'(x);
    yv   = IW'(y);
    ph   = PW'(p);
    stb  = 1'b1;
    tick();
    stb  = 1'b0;
  endtask

  // Called right after the accept edge; lat counts clocks to the o_done cycle.
  task automatic wait_done(output longint lat, output longint busy_ok);
    lat     = 0;
    busy_ok = longint'(busy);
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (!done && !busy) busy_ok = 0;
    end
  endtask

  task automatic count_done(input int cycles, output longint n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
  endtask

  function automatic longint sx();
    return longint'($signed(xo));
  endfunction
  function automatic longint sy();
    return longint'($signed(yo));
  endfunction
  function automatic longint sp();
    return longint'($signed(pho));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint lat, bok, n, xcap;
    rst = 1'b1; stb = 1'b0; mode = 1'b0; xv = '0; yv = '0; ph = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_x", sx(), 0, 0);
    check("rst_y", sy(), 0, 0);
    check("rst_phase", longint'(pho), 0, 0);

    // Rotate by 0
    start(1'b0, 16384, 0, 0);
    wait_done(lat, bok);
    check("rot0_lat", lat, Lat, 0);
    check("rot0_busy_run", bok, 1, 0);
    check("rot0_busy_done", longint'(busy), 0, 0);
    check("rot0_x", sx(), 26981, 2);
    check("rot0_y", sy(), 0, 2);
    check("rot0_resid", sp(), 0, Ang18);

    // Back-to-back: accepted in the done cycle, rotate by 90
    start(1'b0, 16384, 0, 64'h40000000);
    wait_done(lat, bok);
    check("rot90_lat", lat, Lat, 0);
    check("rot90_x", sx(), 0, 2);
    check("rot90_y", sy(), 26981, 2);
    check("rot90_resid", sp(), 0, Ang18);

    // +45 and -45 degrees
    start(1'b0, 16384, 0, 64'h20000000);
    wait_done(lat, bok);
    check("rot45_x", sx(), 19078, 2);
    check("rot45_y", sy(), 19078, 2);
    start(1'b0, 16384, 0, 64'hE0000000);
    wait_done(lat, bok);
    check("rotm45_x", sx(), 19078, 2);
    check("rotm45_y", sy(), -19078, 2);

    // Vector mode, x < 0 (phase input must be ignored)
    start(1'b1, -10000, 10000, 64'h12345678);
    wait_done(lat, bok);
    check("vec_lat", lat, Lat, 0);
    check("vec_x", sx(), 23289, 3);
    check("vec_y", sy(), 0, 2);
    check("vec_phase", longint'(pho), 64'h60000000, 16384);

    // Vector mode, x > 0: atan2(4,3) = 53.13 deg
    start(1'b1, 3000, 4000, 0);
    wait_done(lat, bok);
    check("vec34_x", sx(), 8234, 3);
    check("vec34_phase", longint'(pho), 633866736, 16384);

    // Saturation, both signs
    start(1'b0, 30000, 0, 0);
    wait_done(lat, bok);
    check("sat_pos_x", sx(), 32767, 0);
    check("sat_pos_y", sy(), 0, 2);
    start(1'b0, 30000, 0, 64'h80000000);
    wait_done(lat, bok);
    check("sat_neg_x", sx(), -32767, 0);
    repeat (5) tick();
    check("hold_x", sx(), -32767, 0);

    // Strobe while busy is ignored
    start(1'b0, 16384, 0, 0);
    repeat (4) tick();
    stb = 1'b1; mode = 1'b1; xv = IW'(30000);
    tick();
    stb = 1'b0;
    n = 0; xcap = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        n++;
        xcap = sx();
      end
    end
    check("busy_ign_ndone", n, 1, 0);
    check("busy_ign_x", xcap, 26981, 2);

    // Reset mid-operation aborts
    start(1'b0, 16384, 0, 0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", longint'(busy), 0, 0);
    check("abort_x", sx(), 0, 0);
    check("abort_y", sy(), 0, 0);
    check("abort_phase", longint'(pho), 0, 0);
    count_done(30, n);
    check("abort_ndone", n, 0, 0);
    start(1'b0, 16384, 0, 64'h40000000);
    wait_done(lat, bok);
    check("post_abort_lat", lat, Lat, 0);
    check("post_abort_y", sy(), 26981, 2);

    // Reset wins over a simultaneous strobe
    rst = 1'b1; stb = 1'b1; mode = 1'b0; xv = IW'(16384); yv = '0; ph = '0;
    tick();
    rst = 1'b0; stb = 1'b0;
    check("rst_stb_busy", longint'(busy), 0, 0);
    count_done(30, n);
    check("rst_stb_ndone", n, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
